// File: rtl/adc_bridge_pkg.sv
// adc_bridge_pkg: controller state encoding and serial frame geometry shared by the ADC bridge blocks
package adc_bridge_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT_CFG, LOAD, WAIT_CONV, SHIFT_RES, DONE} state_t;

    localparam int CFG_BITS = 33;
    localparam int RES_BITS = 20;
    localparam int RES_LSB  = 2;
    localparam int RES_MSB  = 17;

endpackage

// File: rtl/adc_sclk_gen.sv
// adc_sclk_gen: sclk divider (CLK_DIV low cycles then CLK_DIV high cycles) with phase strobes
// Held with sclk low and the divider cleared while en=0, so every enable starts on a fresh low phase.
module adc_sclk_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic low_start,
    output logic sample,
    output logic rise
);

    logic [7:0] cnt;
    logic       last;

    assign last      = cnt == 8'(CLK_DIV - 1);
    assign sample    = en && !sclk && last;
    assign rise      = sample;
    assign low_start = en && sclk && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            sclk <= 1'b0;
        end else if (last) begin
            cnt  <= '0;
            sclk <= ~sclk;
        end else begin
            cnt  <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/adc_bridge_ctrl.sv
// adc_bridge_ctrl: shifts a 33-bit config frame to an ADC bridge, loads it, waits for conversion, reads 20 bits back.
// Optional WAIT_CONV watchdog and timeout port: define ADC_BRIDGE_CTRL_TIMEOUT_EN.
module adc_bridge_ctrl
    import adc_bridge_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cfg1,
    input  logic [15:0] cfg2,
    input  logic        cfg_mode,
    output logic        busy,
    output logic        done,
`ifdef ADC_BRIDGE_CTRL_TIMEOUT_EN
    output logic        timeout,
`endif
    output logic [15:0] result,
    output logic [3:0]  res_stat,
    output logic        sclk,
    output logic        sd_o,
    output logic        sload,
    input  logic        sd_i,
    input  logic        conv_fin
);

    state_t              state, state_n;
    logic [CFG_BITS-1:0] frame;
    logic [RES_BITS-1:0] res;
    logic [5:0]          bcnt;
    logic                low_start, sample, rise, to_hit;

    assign busy  = state inside {SHIFT_CFG, LOAD, WAIT_CONV, SHIFT_RES};
    assign done  = state == DONE;
    assign sload = state == LOAD;

    adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk(clk), .rst_n(rst_n), .en(busy), .sclk(sclk),
        .low_start(low_start), .sample(sample), .rise(rise)
    );

`ifdef ADC_BRIDGE_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tcnt;
    // abort at the end of a period so sclk is already low when busy drops
    assign to_hit = low_start && tcnt == TW'(TIMEOUT_CYC);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt    <= '0;
            timeout <= 1'b0;
        end else begin
            tcnt    <= state != WAIT_CONV ? '0 : tcnt + TW'(rise && !conv_fin);
            timeout <= state == WAIT_CONV && to_hit;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? SHIFT_CFG : IDLE;
            SHIFT_CFG: state_n = low_start && bcnt == 6'(CFG_BITS - 1) ? LOAD : SHIFT_CFG;
            LOAD:      state_n = low_start ? WAIT_CONV : LOAD;
            WAIT_CONV: state_n = rise && conv_fin ? SHIFT_RES : to_hit ? IDLE : WAIT_CONV;
            SHIFT_RES: state_n = low_start && bcnt == 6'(RES_BITS) ? DONE : SHIFT_RES;
            default:   state_n = IDLE;
        endcase
    end

    // the start edge opens the first low phase, so bit 0 goes out right away
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame    <= '0;
            res      <= '0;
            bcnt     <= '0;
            sd_o     <= 1'b0;
            result   <= '0;
            res_stat <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    frame <= {cfg_mode, cfg2, cfg1};
                    sd_o  <= cfg1[0];
                    bcnt  <= '0;
                end
                SHIFT_CFG: if (low_start) begin
                    frame <= frame >> 1;
                    sd_o  <= state_n == LOAD ? 1'b0 : frame[1];
                    bcnt  <= state_n == LOAD ? 6'd0 : bcnt + 6'd1;
                end
                SHIFT_RES: begin
                    if (sample) begin
                        res  <= {sd_i, res[RES_BITS-1:1]};
                        bcnt <= bcnt + 6'd1;
                    end
                    if (state_n == DONE) begin
                        result   <= res[RES_MSB:RES_LSB];
                        res_stat <= {res[RES_BITS-1], res[RES_BITS-2], res[1], res[0]};
                        bcnt     <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_bridge_ctrl.sv
// tb_adc_bridge_ctrl: directed scoreboard bench for adc_bridge_ctrl driving a behavioural bridge model.
module tb_adc_bridge_ctrl;

    localparam int CLK_DIV     = 1;
    localparam int TIMEOUT_CYC = 8;

    logic        clk = 0, rst_n = 1, start = 0, cfg_mode = 0;
    logic [15:0] cfg1 = 0, cfg2 = 0;
    logic        busy, done, timeout, sclk, sd_o, sload;
    logic        sd_i = 0, conv_fin = 0;
    logic [15:0] result;
    logic [3:0]  res_stat;

    typedef struct {
        logic        is_to;
        logic [15:0] res;
        logic [3:0]  st;
        logic [32:0] frame;
        int          w;
    } exp_t;

    exp_t q[$];
    int   pass_cnt = 0, tot_cnt = 0, done_cyc = 0;
    int   rises = 0, hi = 0, bc = 0, sl = 0, slr = 0;
    logic sclk_q = 0;

    logic [32:0] sr = 0, cfg_seen = 0;
    logic [19:0] fo = 0;
    int          w_set = 1, m_st = 0, wcnt = 0, rcnt = 0;

    adc_bridge_ctrl #(.CLK_DIV(CLK_DIV), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg1(cfg1), .cfg2(cfg2), .cfg_mode(cfg_mode),
        .busy(busy), .done(done),
`ifdef ADC_BRIDGE_CTRL_TIMEOUT_EN
        .timeout(timeout),
`endif
        .result(result), .res_stat(res_stat), .sclk(sclk), .sd_o(sd_o), .sload(sload),
        .sd_i(sd_i), .conv_fin(conv_fin)
    );

`ifndef ADC_BRIDGE_CTRL_TIMEOUT_EN
    assign timeout = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // bridge: shifts sd_o on every sclk rise, latches the frame on the load rise,
    // raises conv_fin for the w_set-th wait sample (never if 0), then returns fo LSB first
    initial forever begin
        @(posedge sclk or negedge sclk or negedge rst_n);
        if (!rst_n) begin
            m_st = 0; conv_fin = 0; sd_i = 0;
        end else if (sclk) begin
            if (sload) begin
                cfg_seen = sr; m_st = 1; wcnt = 0;
            end else begin
                sr = {sd_o, sr[32:1]};
                if (m_st == 1) begin
                    wcnt++;
                    if (conv_fin) begin m_st = 2; rcnt = 0; end
                end else if (m_st == 2) begin
                    rcnt++;
                    if (rcnt == 20) m_st = 0;
                end
            end
        end else begin
            conv_fin = m_st == 1 && w_set != 0 && wcnt + 1 >= w_set;
            sd_i = (m_st == 2 && rcnt < 20) ? fo[rcnt] : 1'b0;
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                rises = 0; hi = 0; bc = 0; sl = 0; slr = 0;
            end else begin
                if (busy) begin
                    bc++;
                    if (sclk) hi++;
                    if (sload) sl++;
                    if (sclk && !sclk_q) begin
                        rises++;
                        if (sload) slr++;
                    end
                end
                if (done || timeout) begin
                    if (done) done_cyc++;
                    if (q.size() == 0) chk("unexpected_completion", {done, timeout}, 0);
                    else begin
                        e = q.pop_front();
                        chk("completion_kind", timeout, e.is_to);
                        chk("busy_at_end", busy, 0);
                        chk("result", result, e.res);
                        chk("res_stat", res_stat, e.st);
                        chk("bridge_frame", cfg_seen, e.frame);
                        chk("sload_rises", slr, 1);
                        chk("sload_cycles", sl, 2 * CLK_DIV);
                        chk("sclk_rises", rises, e.is_to ? 34 + TIMEOUT_CYC : 54 + e.w);
                        if (!e.is_to) begin
                            chk("busy_cycles", bc, 2 * CLK_DIV * (54 + e.w));
                            chk("sclk_high_cycles", hi, CLK_DIV * (54 + e.w));
                        end
                    end
                    rises = 0; hi = 0; bc = 0; sl = 0; slr = 0;
                end
            end
            sclk_q = sclk;
        end
    end

    task automatic expect_txn(input logic [15:0] c1, input logic [15:0] c2, input logic m,
                              input logic [15:0] rr, input logic [3:0] ss, input int w);
        exp_t e;
        e.is_to = 1'b0; e.res = rr; e.st = ss; e.frame = {m, c2, c1}; e.w = w;
        q.push_back(e);
        w_set = w;
        fo = {ss[3], ss[2], rr, ss[1], ss[0]};
    endtask

    task automatic kick(input logic [15:0] c1, input logic [15:0] c2, input logic m);
        @(negedge clk);
        cfg1 = c1; cfg2 = c2; cfg_mode = m; start = 1;
        @(negedge clk);
        start = 0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < 5000, 1);
        @(negedge clk);
    endtask

    initial begin
        int n;
        #1 rst_n = 0;
        #20;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_sd_o", sd_o, 0);
        chk("rst_sload", sload, 0);
        chk("rst_result", result, 0);
        chk("rst_res_stat", res_stat, 0);
`ifdef ADC_BRIDGE_CTRL_TIMEOUT_EN
        chk("rst_timeout", timeout, 0);
`endif
        rst_n = 1;
        repeat (2) @(negedge clk);

        expect_txn(16'h8842, 16'h3000, 1'b1, 16'hdbca, 4'h0, 3);
        kick(16'h8842, 16'h3000, 1'b1);
        wait_idle("wait_functional");

        expect_txn(16'h1234, 16'habcd, 1'b0, 16'h5a3c, 4'b1010, 1);
        kick(16'h1234, 16'habcd, 1'b0);
        wait_idle("wait_status");

        expect_txn(16'h0f0f, 16'hf0f0, 1'b0, 16'h0001, 4'b0101, 5);
        kick(16'h0f0f, 16'hf0f0, 1'b0);
        repeat (10) @(negedge clk);
        chk("busy_mid_cfg", busy, 1);
        cfg1 = 16'hffff; cfg2 = 16'hffff; cfg_mode = 1; start = 1;
        @(negedge clk);
        start = 0;
        wait_idle("wait_start_busy");
        repeat (4) @(negedge clk);
        chk("no_second_txn", busy, 0);

        w_set = 2;
        fo = 20'h12345;
        kick(16'h1111, 16'h2222, 1'b1);
        n = 0;
        while (!(m_st == 2 && rcnt >= 5) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_shift_res", n < 5000, 1);
        #2 rst_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sclk", sclk, 0);
        chk("abort_sd_o", sd_o, 0);
        chk("abort_sload", sload, 0);
        chk("abort_result", result, 0);
        chk("abort_res_stat", res_stat, 0);
        repeat (3) @(negedge clk);
        chk("no_done_on_abort", done_cyc, 3);
        rst_n = 1;
        repeat (2) @(negedge clk);

        expect_txn(16'h8842, 16'h3000, 1'b1, 16'h8001, 4'hf, 2);
        kick(16'h8842, 16'h3000, 1'b1);
        wait_idle("wait_after_reset");

`ifdef ADC_BRIDGE_CTRL_TIMEOUT_EN
        begin
            exp_t e;
            e.is_to = 1'b1; e.res = 16'h8001; e.st = 4'hf; e.frame = {1'b1, 16'h5555, 16'haaaa}; e.w = 0;
            q.push_back(e);
            w_set = 0;
            kick(16'haaaa, 16'h5555, 1'b1);
            wait_idle("wait_timeout");
        end
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        chk("done_cycles", done_cyc, 4);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/adc_bridge_ctrl.md
ADC_BRIDGE_CTRL -- requirements
Module: adc_bridge_ctrl

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 2; sclk half-period in clk cycles, legal range 1..255.
REQ-002 SHALL provide parameter TIMEOUT_CYC, default 4096; maximum number of sclk periods spent in WAIT_CONV.
REQ-003 SHALL provide ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to run one transaction.
- cfg1  in  16  config word 1.
- cfg2  in  16  config word 2.
- cfg_mode  in  1  frame bit 32.
- busy  out  1  transaction in progress.
- done  out  1  one-cycle completion pulse.
- timeout  out  1  one-cycle pulse on abort; present only with the macro in REQ-017.
- result  out  16  ADC result.
- res_stat  out  4  frame bits {19,18,1,0}.
- sclk  out  1  bridge clock.
- sd_o  out  1  to bridge dat_i.
- sload  out  1  to bridge load.
- sd_i  in  1  from bridge dat_o.
- conv_fin  in  1  from bridge conv_finish.

Function
REQ-004 SHALL implement states IDLE, SHIFT_CFG, LOAD, WAIT_CONV, SHIFT_RES, DONE.
REQ-005 sclk SHALL idle low; each sclk period SHALL be CLK_DIV clk cycles low followed by CLK_DIV clk cycles high.
REQ-006 sd_o and sload SHALL change only on the clk edge that starts a low phase.
REQ-007 sd_i and conv_fin SHALL be sampled on the last clk cycle of a low phase.
REQ-008 In IDLE, start=1 SHALL latch {cfg_mode,cfg2,cfg1} as a 33-bit frame, assert busy on the next cycle, and enter SHIFT_CFG.
REQ-009 start SHALL be ignored while busy=1.
REQ-010 SHIFT_CFG SHALL present frame bits 0..32 LSB first on sd_o, one bit per sclk period (33 periods), then enter LOAD with sd_o=0.
REQ-011 LOAD SHALL hold sload=1 for exactly one sclk period, then enter WAIT_CONV with sload=0.
REQ-012 WAIT_CONV SHALL generate sclk and enter SHIFT_RES after the first sample with conv_fin=1.
REQ-013 SHIFT_RES SHALL sample 20 bits into a 20-bit register, bit index i taken at sample i, one sample per sclk period.
REQ-014 On completion of SHIFT_RES: result SHALL equal bits [17:2]; res_stat SHALL equal {b19,b18,b1,b0}; both SHALL be updated together; state SHALL enter DONE.
REQ-015 DONE SHALL pulse done for one clk cycle, deassert busy in that same cycle, and return to IDLE.
REQ-016 result and res_stat SHALL hold their values until the next successful completion.

Configuration
REQ-017 With ADC_BRIDGE_CTRL_TIMEOUT_EN defined:
- A counter SHALL count sclk periods in WAIT_CONV.
- On reaching TIMEOUT_CYC without conv_fin, the block SHALL pulse timeout for one cycle, deassert busy, leave result unchanged, and return to IDLE.
- Without the macro: no timeout port, no counter, and WAIT_CONV waits indefinitely.

Reset
REQ-018 rst_n=0 SHALL asynchronously force state IDLE, sclk=0, sd_o=0, sload=0, busy=0, done=0, timeout=0, result=0, res_stat=0, and clear all counters.
REQ-019 Reset during any state SHALL abort the transaction with no done pulse.
REQ-020 The first start after reset release SHALL begin a complete fresh frame.

Structure
REQ-021 A shared package adc_bridge_pkg SHALL hold:
- the state enum;
- the constants CFG_BITS=33, RES_BITS=20, RES_LSB=2, RES_MSB=17.
REQ-022 The sclk divider and phase strobes (low_start, sample, rise) SHALL be a sub-module adc_sclk_gen, enabled only while busy=1.

Verification
REQ-023 Verification SHALL cover these directed scenarios:
- Functional, against a bridge model: cfg1=16'h8842, cfg2=16'h3000, cfg_mode=1, start pulse, model result 16'hdbca -> bridge shows cfg1=8842 and cfg2=3000; result=16'hdbca; exactly one done pulse.
- Timing, CLK_DIV=1: count sclk rising edges from start to done -> 33+1+W+20, where W is the number of WAIT_CONV periods; sload is high for exactly one sclk period.
- Start while busy: assert start during SHIFT_CFG -> ignored; exactly one transaction completes.
- Reset mid-operation: reset asserted during SHIFT_RES -> all outputs are 0 immediately; no done pulse; the next transaction completes correctly.
- Timeout (macro defined, TIMEOUT_CYC=8, conv_fin held at 0) -> timeout pulses after 8 WAIT_CONV periods; busy=0; result keeps its previous value.
- Status bits: model frame bits {19,18,1,0}=4'b1010 -> res_stat=4'b1010, with result unaffected.
